// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus CPU.
// Purpose : steps through fetch (T0-T1) and an opcode-specific execute phase
//           (T2-T4), decoding the step, opcode and ALU flags into every bus
//           strobe of the datapath, and latching the clock-halt on HLT.
// Ports   : i_CLOCK       CPU clock, state changes on its rising edge
//           i_CLEAR       asynchronous active-high reset
//           i_OPCODE      IR upper nibble
//           i_ZERO_FLAG   registered ALU zero flag (sampled in T2 of JZ)
//           i_CARRY_FLAG  registered ALU carry flag (sampled in T2 of JC)
//           o_*           datapath strobes (_n suffix = active low)
//           o_STEP        current micro-step, for LEDs
// Macro   : CONTROL_SEQUENCER_EARLY_END_EN - when defined, instructions end
//           at their last used step; otherwise every instruction runs T0-T4.
module control_sequencer #(
   parameter int OPCODE_WIDTH = 4,
   parameter int STEP_WIDTH   = 3
) (
   input  logic                    i_CLOCK,
   input  logic                    i_CLEAR,
   input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
   input  logic                    i_ZERO_FLAG,
   input  logic                    i_CARRY_FLAG,
   output logic                    o_PC_COUNT_ENABLE,
   output logic                    o_PC_JUMP_n,
   output logic                    o_PC_WRITE_BUS_n,
   output logic                    o_A_READ_BUS_n,
   output logic                    o_A_WRITE_BUS_n,
   output logic                    o_B_READ_BUS_n,
   output logic                    o_IR_READ_BUS_n,
   output logic                    o_IR_WRITE_BUS_n,
   output logic                    o_ALU_WRITE_BUS_n,
   output logic                    o_ALU_SUBTRACT,
   output logic                    o_FLAGS_UPDATE_n,
   output logic                    o_MAR_READ_BUS_n,
   output logic                    o_RAM_READ_BUS,
   output logic                    o_RAM_WRITE_BUS_n,
   output logic                    o_OUT_READ_BUS,
   output logic                    o_CLOCK_HALT,
   output logic [STEP_WIDTH-1:0]   o_STEP
);
   logic [STEP_WIDTH-1:0] r_STEP, next_step, last_step;
   logic r_HALTED, next_halted;
   logic t0, t1, t2, t3, t4, live;
   logic is_lda, is_alu, is_sub, is_sta, is_ldi, is_jump, is_out, is_hlt;
   always_ff @(posedge i_CLOCK or posedge i_CLEAR)
      if (i_CLEAR) begin
         r_STEP   <= '0;
         r_HALTED <= 1'b0;
      end else begin
         r_STEP   <= next_step;
         r_HALTED <= next_halted;
      end
   assign t0 = r_STEP == STEP_WIDTH'(0);
   assign t1 = r_STEP == STEP_WIDTH'(1);
   assign t2 = r_STEP == STEP_WIDTH'(2);
   assign t3 = r_STEP == STEP_WIDTH'(3);
   assign t4 = r_STEP == STEP_WIDTH'(4);
   assign is_lda  = i_OPCODE == OPCODE_WIDTH'(1);
   assign is_sub  = i_OPCODE == OPCODE_WIDTH'(3);
   assign is_alu  = i_OPCODE == OPCODE_WIDTH'(2) || is_sub;
   assign is_sta  = i_OPCODE == OPCODE_WIDTH'(4);
   assign is_ldi  = i_OPCODE == OPCODE_WIDTH'(5);
   // JC/JZ become a plain JMP when their flag is set, otherwise a NOP.
   assign is_jump = i_OPCODE == OPCODE_WIDTH'(6)
                 || (i_OPCODE == OPCODE_WIDTH'(7) && i_CARRY_FLAG)
                 || (i_OPCODE == OPCODE_WIDTH'(8) && i_ZERO_FLAG);
   assign is_out  = i_OPCODE == OPCODE_WIDTH'(14);
   assign is_hlt  = i_OPCODE == OPCODE_WIDTH'(15);
   // Clear forces every strobe inactive without waiting for the register.
   assign live = !i_CLEAR && !r_HALTED;
   always_comb begin
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
      last_step = (is_lda || is_sta) ? STEP_WIDTH'(3) : is_alu ? STEP_WIDTH'(4) : STEP_WIDTH'(2);
`else
      last_step = STEP_WIDTH'(4);
`endif
      next_halted = r_HALTED || (t2 && is_hlt);
      next_step   = next_halted ? r_STEP : (r_STEP >= last_step) ? '0 : r_STEP + STEP_WIDTH'(1);
   end
   always_comb begin
      o_PC_WRITE_BUS_n  = !(live && t0);
      o_MAR_READ_BUS_n  = !(live && (t0 || (t2 && (is_lda || is_alu || is_sta))));
      o_RAM_WRITE_BUS_n = !(live && (t1 || (t3 && (is_lda || is_alu))));
      o_IR_READ_BUS_n   = !(live && t1);
      o_PC_COUNT_ENABLE = live && t1;
      o_IR_WRITE_BUS_n  = !(live && t2 && (is_lda || is_alu || is_sta || is_ldi || is_jump));
      o_A_READ_BUS_n    = !(live && ((t3 && is_lda) || (t4 && is_alu) || (t2 && is_ldi)));
      o_B_READ_BUS_n    = !(live && t3 && is_alu);
      o_ALU_WRITE_BUS_n = !(live && t4 && is_alu);
      o_ALU_SUBTRACT    = live && (t3 || t4) && is_sub;
      o_FLAGS_UPDATE_n  = !(live && t4 && is_alu);
      o_PC_JUMP_n       = !(live && t2 && is_jump);
      o_RAM_READ_BUS    = live && t3 && is_sta;
      o_A_WRITE_BUS_n   = !(live && ((t3 && is_sta) || (t2 && is_out)));
      o_OUT_READ_BUS    = live && t2 && is_out;
      o_CLOCK_HALT      = !i_CLEAR && (r_HALTED || (t2 && is_hlt));
   end
   assign o_STEP = r_STEP;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
module tb_control_sequencer;
   localparam logic [15:0] PCE = 16'h8000, JMP = 16'h4000, PCO = 16'h2000, AI = 16'h1000;
   localparam logic [15:0] AO  = 16'h0800, BI  = 16'h0400, II  = 16'h0200, IO = 16'h0100;
   localparam logic [15:0] EO  = 16'h0080, SU  = 16'h0040, FI  = 16'h0020, MI = 16'h0010;
   localparam logic [15:0] RI  = 16'h0008, RO  = 16'h0004, OI  = 16'h0002, HL = 16'h0001;
   localparam logic [15:0] POL = 16'h7FB4;
   localparam logic [15:0] FETCH0 = PCO | MI, FETCH1 = PCE | RO | II;
   logic clk = 1'b0, clear = 1'b1, zero = 1'b0, carry = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic pc_ce, pc_jump_n, pc_wr_n, a_rd_n, a_wr_n, b_rd_n, ir_rd_n, ir_wr_n;
   logic alu_wr_n, alu_sub, flags_n, mar_rd_n, ram_rd, ram_wr_n, out_rd, halt;
   logic [2:0] step;
   logic [15:0] act;
   int checks = 0, errors = 0;
   control_sequencer dut (
      .i_CLOCK(clk), .i_CLEAR(clear), .i_OPCODE(opcode), .i_ZERO_FLAG(zero), .i_CARRY_FLAG(carry),
      .o_PC_COUNT_ENABLE(pc_ce), .o_PC_JUMP_n(pc_jump_n), .o_PC_WRITE_BUS_n(pc_wr_n),
      .o_A_READ_BUS_n(a_rd_n), .o_A_WRITE_BUS_n(a_wr_n), .o_B_READ_BUS_n(b_rd_n),
      .o_IR_READ_BUS_n(ir_rd_n), .o_IR_WRITE_BUS_n(ir_wr_n), .o_ALU_WRITE_BUS_n(alu_wr_n),
      .o_ALU_SUBTRACT(alu_sub), .o_FLAGS_UPDATE_n(flags_n), .o_MAR_READ_BUS_n(mar_rd_n),
      .o_RAM_READ_BUS(ram_rd), .o_RAM_WRITE_BUS_n(ram_wr_n), .o_OUT_READ_BUS(out_rd),
      .o_CLOCK_HALT(halt), .o_STEP(step)
   );
   always #5 clk = ~clk;
   assign act = {pc_ce, pc_jump_n, pc_wr_n, a_rd_n, a_wr_n, b_rd_n, ir_rd_n, ir_wr_n,
                 alu_wr_n, alu_sub, flags_n, mar_rd_n, ram_rd, ram_wr_n, out_rd, halt} ^ POL;
   task automatic restart();
      @(posedge clk);
      #1 clear = 1'b1;
      #2 clear = 1'b0;
      #1;
   endtask
   task automatic test_reset();
      opcode = 4'h0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (act !== 16'h0 || step !== 3'd0) begin
         errors++;
         $display("FAIL reset: strobes=%h step=%0d, required strobes=0000 step=0", act, step);
      end
      clear = 1'b0;
      #1;
   endtask
   task automatic test_fetch_nop();
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
      logic [2:0]  s[4] = '{3'd0, 3'd1, 3'd2, 3'd0};
      logic [15:0] e[4] = '{FETCH0, FETCH1, 16'h0, FETCH0};
`else
      logic [2:0]  s[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      logic [15:0] e[6] = '{FETCH0, FETCH1, 16'h0, 16'h0, 16'h0, FETCH0};
`endif
      for (int i = 0; i < $size(s); i++) begin
         checks++;
         if (act !== e[i] || step !== s[i]) begin
            errors++;
            $display("FAIL fetch_nop[%0d]: strobes=%h step=%0d, required strobes=%h step=%0d", i, act, step, e[i], s[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask
   task automatic test_execute();
      logic [3:0]  op[13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7, 4'h8, 4'h8, 4'hB, 4'hE};
      logic        zf[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      logic        cf[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
      logic [15:0] e2[13] = '{16'h0, IO|MI, IO|MI, IO|MI, IO|MI, IO|AI, IO|JMP, 16'h0, IO|JMP, 16'h0, IO|JMP, 16'h0, AO|OI};
      logic [15:0] e3[13] = '{16'h0, RO|AI, RO|BI, RO|BI|SU, AO|RI, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      logic [15:0] e4[13] = '{16'h0, 16'h0, EO|AI|FI, EO|AI|FI|SU, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      logic [2:0]  ls[13] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
      logic [15:0] e;
      int last;
      restart();
      for (int k = 0; k < 13; k++) begin
         opcode = op[k];
         zero   = zf[k];
         carry  = cf[k];
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
         last = int'(ls[k]);
`else
         last = 4;
`endif
         for (int s = 0; s <= last + 1; s++) begin
            e = (s == 0 || s == last + 1) ? FETCH0 : s == 1 ? FETCH1 : s == 2 ? e2[k] : s == 3 ? e3[k] : e4[k];
            checks++;
            if (act !== e || int'(step) !== (s == last + 1 ? 0 : s)) begin
               errors++;
               $display("FAIL execute op=%h z=%0d c=%0d t%0d: strobes=%h step=%0d, required strobes=%h step=%0d",
                        op[k], zf[k], cf[k], s, act, step, e, (s == last + 1 ? 0 : s));
            end
            if (s <= last) begin
               @(posedge clk);
               #1;
            end
         end
      end
      zero = 1'b0;
      carry = 1'b0;
   endtask
   task automatic test_halt();
      restart();
      opcode = 4'hF;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (act !== HL || step !== 3'd2) begin
         errors++;
         $display("FAIL halt_t2: strobes=%h step=%0d, required strobes=%h step=2", act, step, HL);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 4) opcode = 4'h2;
         @(posedge clk);
         #1;
         checks++;
         if (act !== HL || step !== 3'd2) begin
            errors++;
            $display("FAIL halt_hold[%0d]: strobes=%h step=%0d, required strobes=%h step=2", i, act, step, HL);
         end
      end
      opcode = 4'h0;
      clear = 1'b1;
      #1;
      checks++;
      if (act !== 16'h0 || step !== 3'd0) begin
         errors++;
         $display("FAIL halt_clear: strobes=%h step=%0d, required strobes=0000 step=0", act, step);
      end
      clear = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (act !== FETCH1 || step !== 3'd1) begin
         errors++;
         $display("FAIL halt_resume: strobes=%h step=%0d, required strobes=%h step=1", act, step, FETCH1);
      end
   endtask
   task automatic test_async_clear();
      restart();
      opcode = 4'h4;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (act !== (AO | RI) || step !== 3'd3) begin
         errors++;
         $display("FAIL sta_t3: strobes=%h step=%0d, required strobes=%h step=3", act, step, AO | RI);
      end
      #2 clear = 1'b1;
      #1;
      checks++;
      if (ram_rd !== 1'b0 || act !== 16'h0 || step !== 3'd0) begin
         errors++;
         $display("FAIL async_clear: ram_rd=%b strobes=%h step=%0d, required ram_rd=0 strobes=0000 step=0", ram_rd, act, step);
      end
      #1 clear = 1'b0;
      #1;
      checks++;
      if (act !== FETCH0 || step !== 3'd0) begin
         errors++;
         $display("FAIL after_clear_t0: strobes=%h step=%0d, required strobes=%h step=0", act, step, FETCH0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (act !== FETCH1 || step !== 3'd1) begin
         errors++;
         $display("FAIL after_clear_t1: strobes=%h step=%0d, required strobes=%h step=1", act, step, FETCH1);
      end
   endtask
   initial begin
      test_reset();
      test_fetch_nop();
      test_execute();
      test_halt();
      test_async_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
